// File: rtl/jk_universal_register.sv
// WIDTH-bit register with per-bit JK semantics plus hold, load, shift, modulo count and clear.
// Everything is synchronous to i_clk; i_rst is a synchronous active-high clear.
module jk_universal_register #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic             o_sout,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_JK    = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_SHL   = 3'b100;
    localparam logic [2:0] M_UP    = 3'b101;
    localparam logic [2:0] M_DOWN  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_wrap;

    logic [WIDTH-1:0] w_jk;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;
    logic             w_wrap_next;

    // Every bit sees the pre-edge Q: next = J&~Q | ~K&Q
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
            assign w_jk[gi] = (i_j[gi] & ~r_q[gi]) | (~i_k[gi] & r_q[gi]);
        end
    endgenerate

    generate
        if (WIDTH == 1) begin : g_shift_1
            assign w_shr = i_sin;
            assign w_shl = i_sin;
        end else begin : g_shift_n
            assign w_shr = {i_sin, r_q[WIDTH-1:1]};
            assign w_shl = {r_q[WIDTH-2:0], i_sin};
        end
    endgenerate

    always_comb begin
        w_q_next    = r_q;
        w_sout_next = r_sout;
        w_wrap_next = 1'b0;
        if (i_en) begin
            case (i_mode)
                M_HOLD:  w_q_next = r_q;
                M_LOAD:  w_q_next = i_d;
                M_JK:    w_q_next = w_jk;
                M_SHR: begin
                    w_q_next    = w_shr;
                    w_sout_next = r_q[0];
                end
                M_SHL: begin
                    w_q_next    = w_shl;
                    w_sout_next = r_q[WIDTH-1];
                end
                M_UP: begin
                    // Out-of-range values (>= MODULUS) also wrap to zero
                    if (r_q >= C_MAX) begin
                        w_q_next    = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_q_next = r_q + 1'b1;
                    end
                end
                M_DOWN: begin
                    if (r_q == '0) begin
                        w_q_next    = C_MAX;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_q_next = r_q - 1'b1;
                    end
                end
                M_CLEAR: w_q_next = '0;
                default: w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_sout <= w_sout_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign o_q    = r_q;
    assign o_qbar = ~r_q;
    assign o_sout = r_sout;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_jk_universal_register.sv
// Directed and random checks of jk_universal_register at MODULUS=10 and MODULUS=16
// against an integer reference model of the mode rules.
module tb_jk_universal_register;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] d = '0;
    logic [W-1:0] j = '0;
    logic [W-1:0] k = '0;
    logic         sin = 1'b0;

    logic [W-1:0] q_a, qbar_a, q_b, qbar_b;
    logic         sout_a, wrap_a, sout_b, wrap_b;

    int total = 0;
    int bad   = 0;

    int mq[2];
    int ms[2];
    int mw[2];
    int mmod[2] = '{10, 16};

    always #5 clk = ~clk;

    jk_universal_register #(.WIDTH(W), .MODULUS(10)) u_dec (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d), .i_j(j), .i_k(k),
        .i_sin(sin), .o_q(q_a), .o_qbar(qbar_a), .o_sout(sout_a), .o_wrap(wrap_a)
    );

    jk_universal_register #(.WIDTH(W), .MODULUS(16)) u_hex (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d), .i_j(j), .i_k(k),
        .i_sin(sin), .o_q(q_b), .o_qbar(qbar_b), .o_sout(sout_b), .o_wrap(wrap_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: apply the operation rules to an integer state
    task automatic model(input int n);
        int q;
        int nq;
        q = mq[n];
        if (rst) begin
            mq[n] = 0; ms[n] = 0; mw[n] = 0;
        end else if (!en) begin
            mw[n] = 0;
        end else begin
            mw[n] = 0;
            case (mode)
                3'd1: q = int'(d);
                3'd2: begin
                    nq = 0;
                    for (int b = 0; b < W; b++) begin
                        int qb;
                        qb = (q >> b) & 1;
                        case ({j[b], k[b]})
                            2'b10: qb = 1;
                            2'b01: qb = 0;
                            2'b11: qb = 1 - qb;
                            default: ;
                        endcase
                        nq = nq | (qb << b);
                    end
                    q = nq;
                end
                3'd3: begin ms[n] = q & 1; q = (q >> 1) | (int'(sin) << (W - 1)); end
                3'd4: begin ms[n] = (q >> (W - 1)) & 1; q = ((q << 1) % (1 << W)) | int'(sin); end
                3'd5: begin
                    if (q >= mmod[n] - 1) begin q = 0; mw[n] = 1; end
                    else q = q + 1;
                end
                3'd6: begin
                    if (q == 0) begin q = mmod[n] - 1; mw[n] = 1; end
                    else q = q - 1;
                end
                3'd7: q = 0;
                default: ;
            endcase
            mq[n] = q;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dd, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic s);
        rst = r; en = e; mode = m; d = dd; j = jj; k = kk; sin = s;
        @(posedge clk);
        #1;
        model(0);
        model(1);
        check("dec_q",    int'(q_a),    mq[0]);
        check("dec_qbar", int'(qbar_a), (~mq[0]) & ((1 << W) - 1));
        check("dec_sout", int'(sout_a), ms[0]);
        check("dec_wrap", int'(wrap_a), mw[0]);
        check("hex_q",    int'(q_b),    mq[1]);
        check("hex_qbar", int'(qbar_b), (~mq[1]) & ((1 << W) - 1));
        check("hex_sout", int'(sout_b), ms[1]);
        check("hex_wrap", int'(wrap_b), mw[1]);
        $display("t=%0t rst=%0b en=%0b mode=%0d d=%h j=%h k=%h sin=%0b | dec q=%h s=%0b w=%0b | hex q=%h s=%0b w=%0b",
                 $time, r, e, m, dd, jj, kk, s, q_a, sout_a, wrap_a, q_b, sout_b, wrap_b);
    endtask

    initial begin
        mq = '{0, 0}; ms = '{0, 0}; mw = '{0, 0};
        @(negedge clk);

        // Reset state
        step(1, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
        check("reset_q", int'(q_a), 0);
        check("reset_wrap", int'(wrap_a), 0);

        // Reset mid-count
        for (int i = 0; i < 7; i++) step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("count_to_7", int'(q_a), 7);
        step(1, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("rst_mid_q", int'(q_a), 0);
        check("rst_mid_wrap", int'(wrap_a), 0);
        step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("after_rst_up", int'(q_a), 1);

        // Decade wrap
        step(0, 1, 3'd1, 4'h8, 4'h0, 4'h0, 0);
        step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("dec_up9", int'(q_a), 9);
        check("dec_up9_wrap", int'(wrap_a), 0);
        step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("dec_up0", int'(q_a), 0);
        check("dec_up0_wrap", int'(wrap_a), 1);
        step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("dec_up1", int'(q_a), 1);
        check("dec_up1_wrap", int'(wrap_a), 0);
        step(0, 1, 3'd1, 4'h0, 4'h0, 4'h0, 0);
        step(0, 1, 3'd6, 4'h0, 4'h0, 4'h0, 0);
        check("dec_down_wrap_q", int'(q_a), 9);
        check("dec_down_wrap", int'(wrap_a), 1);
        check("hex_down_wrap_q", int'(q_b), 15);

        // JK truth table, then enable low
        step(0, 1, 3'd1, 4'b1010, 4'h0, 4'h0, 0);
        step(0, 1, 3'd2, 4'h0, 4'b1100, 4'b0110, 0);
        check("jk_table", int'(q_a), 4'b1100);
        step(0, 0, 3'd2, 4'h0, 4'b1100, 4'b0110, 0);
        check("jk_en_low", int'(q_a), 4'b1100);

        // Shifts
        step(0, 1, 3'd1, 4'b1001, 4'h0, 4'h0, 0);
        step(0, 1, 3'd3, 4'h0, 4'h0, 4'h0, 1);
        check("shr_q", int'(q_a), 4'b1100);
        check("shr_sout", int'(sout_a), 1);
        step(0, 1, 3'd4, 4'h0, 4'h0, 4'h0, 0);
        check("shl_q", int'(q_a), 4'b1000);
        check("shl_sout", int'(sout_a), 1);
        step(0, 1, 3'd1, 4'h3, 4'h0, 4'h0, 0);
        check("load_keeps_sout", int'(sout_a), 1);

        // Out-of-range and natural rollover
        step(0, 1, 3'd1, 4'hF, 4'h0, 4'h0, 0);
        step(0, 1, 3'd5, 4'h0, 4'h0, 4'h0, 0);
        check("oor_up_q", int'(q_a), 0);
        check("oor_up_wrap", int'(wrap_a), 1);
        check("hex_roll_q", int'(q_b), 0);
        check("hex_roll_wrap", int'(wrap_b), 1);
        step(0, 1, 3'd1, 4'hF, 4'h0, 4'h0, 0);
        step(0, 1, 3'd6, 4'h0, 4'h0, 4'h0, 0);
        check("oor_down_q", int'(q_a), 4'b1110);
        check("oor_down_wrap", int'(wrap_a), 0);

        // Clear
        step(0, 1, 3'd7, 4'h0, 4'h0, 4'h0, 0);
        check("clear_q", int'(q_a), 0);
        check("clear_wrap", int'(wrap_a), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
